// File: rtl/ultrasonic_burst_driver.sv
// Complementary H-bridge burst generator: N periods of HIGH / dead / LOW / dead,
// timed in tick strobes, with start/busy/done handshake and immediate abort.
module ultrasonic_burst_driver #(
    parameter int unsigned HALF_TICKS = 10,
    parameter int unsigned DEAD_TICKS = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_pulses,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 drive_p,
    output logic                 drive_n,
    output logic [CNT_WIDTH-1:0] pulses_left
);

    localparam int unsigned TICK_W = 8;
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);
    localparam logic [TICK_W-1:0] DEAD_LAST = (DEAD_TICKS == 0) ? '0 : TICK_W'(DEAD_TICKS - 1);
    localparam logic HAS_DEAD = (DEAD_TICKS != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_DEAD_A,
        S_LOW,
        S_DEAD_B
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pulses_left_q, pulses_left_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 drive_p_q, drive_p_d;
    logic                 drive_n_q, drive_n_d;

    logic [TICK_W-1:0]    phase_last;
    logic                 phase_end;
    logic                 period_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pulses_left_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            drive_p_q     <= 1'b0;
            drive_n_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pulses_left_q <= pulses_left_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            drive_p_q     <= drive_p_d;
            drive_n_q     <= drive_n_d;
        end
    end

    // Tick count at which the current phase expires.
    always_comb begin
        phase_last = '0;
        case (state_q)
            S_HIGH, S_LOW:     phase_last = HALF_LAST;
            S_DEAD_A, S_DEAD_B: phase_last = DEAD_LAST;
            default:           phase_last = '0;
        endcase
        phase_end = tick && (cnt_q == phase_last);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pulses_left_d = pulses_left_q;
        done_d        = 1'b0;
        period_end    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_pulses != '0) begin
                        pulses_left_d = num_pulses;
                        cnt_d         = '0;
                        state_d       = S_HIGH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (phase_end) begin
                    cnt_d = '0;
                    case (state_q)
                        S_HIGH:   state_d = HAS_DEAD ? S_DEAD_A : S_LOW;
                        S_DEAD_A: state_d = S_LOW;
                        S_LOW: begin
                            if (HAS_DEAD) state_d = S_DEAD_B;
                            else          period_end = 1'b1;
                        end
                        default:  period_end = 1'b1;
                    endcase
                end else if (tick) begin
                    cnt_d = cnt_q + TICK_W'(1);
                end
            end
        endcase

        // Last period finishes the burst; otherwise start the next HIGH phase.
        if (period_end) begin
            if (pulses_left_q == CNT_WIDTH'(1)) begin
                state_d       = S_IDLE;
                pulses_left_d = '0;
                done_d        = 1'b1;
            end else begin
                state_d       = S_HIGH;
                pulses_left_d = pulses_left_q - CNT_WIDTH'(1);
            end
        end

        if (abort) begin
            state_d       = S_IDLE;
            cnt_d         = '0;
            pulses_left_d = '0;
            done_d        = 1'b0;
        end

        busy_d    = (state_d != S_IDLE);
        drive_p_d = (state_d == S_HIGH);
        drive_n_d = (state_d == S_LOW);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign drive_p     = drive_p_q;
    assign drive_n     = drive_n_q;
    assign pulses_left = pulses_left_q;

endmodule

// File: tb/tb_ultrasonic_burst_driver.sv
// Bench for ultrasonic_burst_driver: two parameterisations driven with shared stimulus,
// each checked every cycle against a burst-position model through a scoreboard queue.
module tb_ultrasonic_burst_driver;

    localparam int unsigned HA = 4;
    localparam int unsigned DA = 1;
    localparam int unsigned HB = 2;
    localparam int unsigned DB = 0;

    logic       clk = 1'b0;
    logic       rst, tick, start, abort;
    logic [7:0] num_pulses;

    logic       busy_a, done_a, drive_p_a, drive_n_a;
    logic [7:0] pulses_left_a;
    logic       busy_b, done_b, drive_p_b, drive_n_b;
    logic [7:0] pulses_left_b;

    int total = 0;
    int bad   = 0;

    logic [11:0] q_a[$];
    logic [11:0] q_b[$];

    int m_active[2];
    int m_t[2];
    int m_n[2];
    int m_done[2];

    int    tick_mode;
    int    div;
    int    busy_cnt_a, busy_cnt_b, done_cnt_a, done_cnt_b;
    string scen;

    always #5 clk = ~clk;

    ultrasonic_burst_driver #(.HALF_TICKS(HA), .DEAD_TICKS(DA), .CNT_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .num_pulses(num_pulses),
        .abort(abort), .busy(busy_a), .done(done_a), .drive_p(drive_p_a),
        .drive_n(drive_n_a), .pulses_left(pulses_left_a)
    );

    ultrasonic_burst_driver #(.HALF_TICKS(HB), .DEAD_TICKS(DB), .CNT_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .num_pulses(num_pulses),
        .abort(abort), .busy(busy_b), .done(done_b), .drive_p(drive_p_b),
        .drive_n(drive_n_b), .pulses_left(pulses_left_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: position t (counted ticks) inside an N-period burst; phase from t mod period.
    task automatic model_step(input int k, output logic [11:0] exp);
        int h, d, p, r;
        logic dp, dn;
        h = (k == 0) ? int'(HA) : int'(HB);
        d = (k == 0) ? int'(DA) : int'(DB);
        p = 2 * (h + d);
        m_done[k] = 0;
        if (rst || abort) begin
            m_active[k] = 0;
        end else if (m_active[k] == 0) begin
            if (start) begin
                if (num_pulses != 8'd0) begin
                    m_active[k] = 1;
                    m_t[k]      = 0;
                    m_n[k]      = int'(num_pulses);
                end else begin
                    m_done[k] = 1;
                end
            end
        end else if (tick) begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == m_n[k] * p) begin
                m_active[k] = 0;
                m_done[k]   = 1;
            end
        end
        if (m_active[k] == 0) begin
            exp = {1'b0, (m_done[k] != 0), 2'b00, 8'd0};
        end else begin
            r   = m_t[k] % p;
            dp  = (r < h);
            dn  = (r >= h + d) && (r < 2 * h + d);
            exp = {1'b1, 1'b0, dp, dn, 8'(m_n[k] - m_t[k] / p)};
        end
    endtask

    task automatic cycle();
        logic [11:0] ea, eb, oa, ob;
        if (tick_mode == 1) begin
            tick = (div == 0);
            div  = (div + 1) % 3;
        end else begin
            tick = (tick_mode == 0);
        end
        model_step(0, ea);
        model_step(1, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(posedge clk);
        #1;
        oa = {busy_a, done_a, drive_p_a, drive_n_a, pulses_left_a};
        ob = {busy_b, done_b, drive_p_b, drive_n_b, pulses_left_b};
        check_val({scen, "_a"}, 32'(oa), 32'(q_a.pop_front()));
        check_val({scen, "_b"}, 32'(ob), 32'(q_b.pop_front()));
        if (busy_a) busy_cnt_a++;
        if (busy_b) busy_cnt_b++;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_counts();
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        start      = 1'b1;
        num_pulses = n;
        cycle();
        start      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; start = 1'b0; abort = 1'b0; num_pulses = 8'd0;
        tick_mode = 0; div = 0;
        clear_counts();

        scen = "reset";
        run(2);
        rst = 1'b0;
        run(2);

        scen = "basic";
        clear_counts();
        pulse_start(8'd3);
        run(39);
        check_val("basic_busy_len_a", 32'(busy_cnt_a), 32'd30);
        check_val("basic_busy_len_b", 32'(busy_cnt_b), 32'd12);
        check_val("basic_done_cnt_a", 32'(done_cnt_a), 32'd1);

        scen = "div3";
        tick_mode = 1; div = 0;
        clear_counts();
        pulse_start(8'd2);
        run(69);
        check_val("div3_busy_len_b", 32'(busy_cnt_b), 32'd24);
        check_val("div3_busy_len_a", 32'(busy_cnt_a), 32'd60);
        tick_mode = 0;

        scen = "zero";
        clear_counts();
        pulse_start(8'd0);
        run(3);
        check_val("zero_done_cnt_a", 32'(done_cnt_a), 32'd1);
        check_val("zero_busy_len_a", 32'(busy_cnt_a), 32'd0);

        scen = "abort";
        clear_counts();
        pulse_start(8'd5);
        run(16);
        abort = 1'b1; start = 1'b1; num_pulses = 8'd5;
        cycle();
        abort = 1'b0; start = 1'b0;
        run(3);
        check_val("abort_done_cnt_a", 32'(done_cnt_a), 32'd0);
        clear_counts();
        pulse_start(8'd1);
        run(12);
        check_val("abort_restart_done_a", 32'(done_cnt_a), 32'd1);
        check_val("abort_restart_busy_a", 32'(busy_cnt_a), 32'd10);

        scen = "restart";
        clear_counts();
        pulse_start(8'd2);
        run(3);
        start = 1'b1; num_pulses = 8'd9;
        run(5);
        start = 1'b0;
        run(20);
        check_val("restart_busy_len_a", 32'(busy_cnt_a), 32'd20);
        check_val("restart_busy_len_b", 32'(busy_cnt_b), 32'd8);

        scen = "rst_mid";
        pulse_start(8'd2);
        run(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(3);

        scen = "stall";
        clear_counts();
        pulse_start(8'd2);
        run(6);
        tick_mode = 2;
        run(50);
        tick_mode = 0;
        run(25);
        check_val("stall_busy_len_a", 32'(busy_cnt_a), 32'd70);
        check_val("stall_busy_len_b", 32'(busy_cnt_b), 32'd58);
        check_val("stall_done_cnt_a", 32'(done_cnt_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ultrasonic_burst_driver.md
Name: ultrasonic_burst_driver

Overview:
- Consumes the one-cycle tick strobe from clk_divider (its div_clk output).
- Generates a burst of N complementary square-wave periods on drive_p / drive_n for the ultrasonic transducer H-bridge.
- Inserts dead time between phases.
- start/busy/done handshake toward the trigger/sequencer logic; abort for emergency stop.

Parameters:
- HALF_TICKS, 10, tick strobes per active half-phase (drive_p or drive_n high); legal range 1..255.
- DEAD_TICKS, 1, tick strobes per dead phase (both drives low); 0 means dead phases are skipped; legal range 0..255.
- CNT_WIDTH, 8, width of num_pulses and pulses_left.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset
- tick  input  1  one-cycle enable strobe from clk_divider; all phase timing counts tick-qualified cycles only
- start  input  1  request a burst; sampled only in IDLE
- num_pulses  input  CNT_WIDTH  full periods to emit; latched when start is accepted
- abort  input  1  stop immediately; priority over everything except rst
- busy  output  1  registered; high from the cycle after acceptance until burst end
- done  output  1  registered one-cycle pulse at normal burst completion
- drive_p  output  1  registered high-side drive
- drive_n  output  1  registered low-side drive
- pulses_left  output  CNT_WIDTH  remaining periods, including the current one

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: state=IDLE; busy=0, done=0, drive_p=0, drive_n=0, pulses_left=0; tick counter=0.
- States: IDLE, HIGH, DEAD_A, LOW, DEAD_B. All outputs are registered, decoded from next-state.
- IDLE:
  - start=1 and num_pulses!=0: latch pulses_left=num_pulses, clear tick counter, go to HIGH.
  - Next cycle: busy=1, drive_p=1.
  - start=1 with num_pulses==0: stay IDLE; done=1 for one cycle; busy and drives stay 0.
- Phase counting:
  - The tick counter increments only on cycles with tick=1.
  - A phase ends on the edge where tick=1 and counter==limit-1; the counter clears on every phase change.
  - A tick coinciding with start acceptance is not counted.
- HIGH: drive_p=1, drive_n=0 for HALF_TICKS ticks, then go to DEAD_A, or to LOW if DEAD_TICKS==0.
- DEAD_A: both drives 0 for DEAD_TICKS ticks, then go to LOW.
- LOW: drive_n=1, drive_p=0 for HALF_TICKS ticks, then go to DEAD_B, or apply the DEAD_B exit rule directly if DEAD_TICKS==0.
- DEAD_B exit (end of period):
  - If pulses_left==1: go to IDLE, pulses_left=0, busy=0, done=1 for one cycle.
  - Otherwise: pulses_left decrements and the state goes to HIGH.
- Invariant: drive_p & drive_n is never 1. With DEAD_TICKS>=1, at least DEAD_TICKS ticks of both-low separate any drive_p/drive_n edge pair.
- start while busy: ignored; num_pulses is not re-latched.
- abort=1 in any state:
  - Next cycle: IDLE, drives 0, busy=0, pulses_left=0, done=0.
  - abort and start in the same cycle: abort wins; the burst is not started.
- rst mid-burst: identical to the reset values above on the next edge.
- tick held low mid-burst: the state holds indefinitely with outputs frozen (no timeout).
- tick tied high (DIV=1 upstream): phase durations are in clk cycles. Period = 2*(HALF_TICKS+DEAD_TICKS) cycles.
- Counter widths: tick counter is 8 bits. pulses_left wraps never; decrement occurs only from values >=2.

Test Plan:
- tick=1 constant, HALF_TICKS=4, DEAD_TICKS=1, start with num_pulses=3 at edge 0 -> drive_p high edges 1-4, both low edge 5, drive_n high edges 6-9, both low edge 10, pattern repeats; busy high for exactly 30 cycles; done=1 for the single cycle after edge 30; pulses_left 3->2->1->0.
- tick from clk_divider DIV=3, HALF_TICKS=2, DEAD_TICKS=0, num_pulses=2 -> drive_p high 6 clk cycles then drive_n high 6 cycles with no gap; 24 busy cycles; never both high.
- start with num_pulses=0 -> done pulses one cycle; busy, drive_p and drive_n stay 0.
- abort asserted in the 2nd LOW phase of a 5-pulse burst -> next cycle drives=0, busy=0, pulses_left=0, done never asserted; a following start produces a full new burst.
- start re-asserted while busy with num_pulses=9 during a 2-pulse burst -> ignored; exactly 2 periods emitted.
- rst asserted mid HIGH phase, then tick stalled low for 50 cycles during a later burst -> all outputs 0 the cycle after rst; during the stall, state and drives hold, and timing resumes exactly when tick returns.
